alu_seq_md: RTL

//  Successor to the single-cycle ALU. Registered execute unit for the RV64 datapath.

---
 rtl/alu_seq_md.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_md.sv
// Registered RV64 execute unit: single-cycle base ALU ops plus iterative
// M-extension multiply/divide behind valid/ready handshakes on both sides.
module alu_seq_md #(
  parameter int INSTRUCTION_ADDR_SIZE = 5,
  parameter int N = 64
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [(2**INSTRUCTION_ADDR_SIZE)-1:0] instruction,
  input  logic [1:0]                           alu_op,
  input  logic [N-1:0]                         data_1,
  input  logic [N-1:0]                         data_2,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [N-1:0]                         data_out,
  output logic                                 illegal
);

  localparam int SHW = $clog2(N);
  localparam int CW  = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N);
  localparam logic [N-1:0]  MIN_VAL  = {1'b1, {(N-1){1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_MUL  = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // M ops are encoded as {2'b10, funct3} so the class falls out of the top bits
  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;
  localparam logic [4:0] OP_ILL    = 5'd31;

  logic [2:0]    state, state_next;
  logic [4:0]    op_q;
  logic [N-1:0]  a_q, b_q;
  logic [N-1:0]  acc_hi, acc_lo, opnd;
  logic [CW-1:0] cnt;
  logic          neg_p, neg_r;

  logic [6:0]    funct7;
  logic [2:0]    funct3;
  logic [4:0]    dec_op;
  logic          is_mul, is_div, a_signed, b_signed;
  logic          div_zero, div_ovf, accept;
  logic [N-1:0]  mag_a, mag_b;
  logic          unused_instr_bits;

  assign funct7 = instruction[31:25];
  assign funct3 = instruction[14:12];
  assign unused_instr_bits = ^{instruction[24:15], instruction[11:0]};

  // Instruction decode into a compact internal op code
  always_comb begin
    dec_op = OP_ILL;
    case (alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (funct7 == 7'b0000001) begin
          dec_op = {2'b10, funct3};
        end else begin
          case ({funct7, funct3})
            10'b0000000_000: dec_op = OP_ADD;
            10'b0100000_000: dec_op = OP_SUB;
            10'b0000000_111: dec_op = OP_AND;
            10'b0000000_110: dec_op = OP_OR;
            10'b0000000_100: dec_op = OP_XOR;
            10'b0000000_001: dec_op = OP_SLL;
            10'b0000000_101: dec_op = OP_SRL;
            10'b0100000_101: dec_op = OP_SRA;
            10'b0000000_010: dec_op = OP_SLT;
            10'b0000000_011: dec_op = OP_SLTU;
            default:         dec_op = OP_ILL;
          endcase
        end
      end
      default: dec_op = OP_ILL;
    endcase
  end

  assign is_mul   = (dec_op[4:2] == 3'b100);
  assign is_div   = (dec_op[4:2] == 3'b101);
  assign a_signed = (dec_op == OP_MUL) || (dec_op == OP_MULH) || (dec_op == OP_MULHSU) ||
                    (dec_op == OP_DIV) || (dec_op == OP_REM);
  assign b_signed = (dec_op == OP_MUL) || (dec_op == OP_MULH) ||
                    (dec_op == OP_DIV) || (dec_op == OP_REM);
  assign mag_a    = (a_signed && data_1[N-1]) ? -data_1 : data_1;
  assign mag_b    = (b_signed && data_2[N-1]) ? -data_2 : data_2;
  assign div_zero = (data_2 == '0);
  assign div_ovf  = ((dec_op == OP_DIV) || (dec_op == OP_REM)) &&
                    (data_1 == MIN_VAL) && (&data_2);
  assign accept   = in_valid && in_ready;

  // Divide-by-zero and signed overflow skip the iterative path entirely
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul)                            state_next = S_MUL;
          else if (is_div && !div_zero && !div_ovf) state_next = S_DIV;
          else                                   state_next = S_EXEC;
        end
      end
      S_EXEC:  state_next = S_DONE;
      S_MUL:   if (cnt == CNT_LAST) state_next = S_DONE;
      S_DIV:   if (cnt == CNT_LAST) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  logic [SHW-1:0] shamt;
  logic [N-1:0]   exec_res;

  assign shamt = b_q[SHW-1:0];

  // Single-cycle results, including the degenerate divide outcomes
  always_comb begin
    exec_res = '0;
    case (op_q)
      OP_ADD:  exec_res = a_q + b_q;
      OP_SUB:  exec_res = a_q - b_q;
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_SLL:  exec_res = a_q << shamt;
      OP_SRL:  exec_res = a_q >> shamt;
      OP_SRA:  exec_res = N'($signed(a_q) >>> shamt);
      OP_SLT:  exec_res = {{(N-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLTU: exec_res = {{(N-1){1'b0}}, (a_q < b_q)};
      OP_DIV, OP_DIVU: exec_res = (b_q == '0) ? '1 : a_q;
      OP_REM, OP_REMU: exec_res = (b_q == '0) ? a_q : '0;
      default: exec_res = '0;
    endcase
  end

  logic [N:0]     mul_sum;
  logic [N:0]     div_shift;
  logic           div_ge;
  logic [N-1:0]   div_diff;
  logic [2*N-1:0] prod, prod_s;
  logic [N-1:0]   quo_s, rem_s, mul_res, div_res;

  // Shift-add keeps the product in {acc_hi, acc_lo}; restoring divide keeps
  // the partial remainder in acc_hi and the quotient in acc_lo
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(N+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[N-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});
  assign div_diff  = div_shift[N-1:0] - opnd;

  assign prod    = {acc_hi, acc_lo};
  assign prod_s  = neg_p ? -prod : prod;
  assign quo_s   = neg_p ? -acc_lo : acc_lo;
  assign rem_s   = neg_r ? -acc_hi : acc_hi;
  assign mul_res = (op_q == OP_MUL) ? prod_s[N-1:0] : prod_s[2*N-1:N];
  assign div_res = op_q[1] ? rem_s : quo_s;

  assign out_valid = (state == S_DONE);

  // Datapath and control registers; results stay frozen through DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      data_out <= '0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= dec_op;
            a_q    <= data_1;
            b_q    <= data_2;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= is_mul ? mag_b : mag_a;
            opnd   <= is_mul ? mag_a : mag_b;
            neg_p  <= (a_signed & data_1[N-1]) ^ (b_signed & data_2[N-1]);
            neg_r  <= a_signed & data_1[N-1];
          end
        end
        S_EXEC: begin
          data_out <= exec_res;
          illegal  <= (op_q == OP_ILL);
        end
        S_MUL: begin
          if (cnt != CNT_LAST) begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[N-1:1]};
            cnt              <= cnt + 1'b1;
          end else begin
            data_out <= mul_res;
            illegal  <= 1'b0;
          end
        end
        S_DIV: begin
          if (cnt != CNT_LAST) begin
            acc_hi <= div_ge ? div_diff : div_shift[N-1:0];
            acc_lo <= {acc_lo[N-2:0], div_ge};
            cnt    <= cnt + 1'b1;
          end else begin
            data_out <= div_res;
            illegal  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
